// File: rtl/demux_1to4_fifo_pkg.sv
// Shared constants for the 1-to-4 demux slice, plus the 4:1 single-bit mux used to pick
// the selected lane's status.
package demux_1to4_fifo_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;
    localparam int LANE2 = 2;
    localparam int LANE3 = 3;

    function automatic logic mux4to1(input logic [LANES-1:0] d, input logic [SEL_W-1:0] sel);
        return d[sel];
    endfunction

endpackage

// File: rtl/demux_1to4_fifo_if.sv
// Producer-side and consumer-side bus of the 1-to-4 demux.
// Valid/ready: a word moves on a rising edge where valid && ready; while valid && !ready the
// sender holds its payload stable, and ready may depend combinationally on the receiver side.
interface demux_1to4_fifo_if #(parameter int N = 16);
    import demux_1to4_fifo_pkg::*;

    logic [N-1:0]       in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [LANES*N-1:0] out_data;
    logic [LANES-1:0]   out_valid;
    logic [LANES-1:0]   out_ready;
    logic [LANES-1:0]   lane_full;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, lane_full
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, lane_full
    );

endinterface

// File: rtl/demux_1to4_fifo_lane_fifo.sv
// One lane buffer: DEPTH-entry circular FIFO with the head presented directly from storage
// (no bypass), so a pushed word appears one edge after it is written.
module lane_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [N-1:0] wr_data,
    input  logic         pop,
    output logic [N-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/demux_1to4_fifo.sv
// Registered 1-to-4 demultiplexer: each accepted word is routed by in_sel into one of four
// lane FIFOs, each drained by its own consumer with independent backpressure.
module demux_1to4_fifo
    import demux_1to4_fifo_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    demux_1to4_fifo_if.slave  bus
);

    logic [LANES-1:0]   push;
    logic [LANES-1:0]   pop;
    logic [LANES-1:0]   empty;
    logic [LANES-1:0]   full;
    logic [N-1:0]       rd_data [LANES];
    logic [LANES*N-1:0] out_data_w;
    logic               sel_full;
    logic               sel_ready;

    // A full lane still accepts when its head leaves this same cycle (out_ready -> in_ready path).
    assign sel_full     = mux4to1(full, bus.in_sel);
    assign sel_ready    = mux4to1(bus.out_ready, bus.in_sel);
    assign bus.in_ready = !sel_full || sel_ready;

    assign push = (bus.in_valid && bus.in_ready) ? (LANES'(1) << bus.in_sel) : '0;
    assign pop  = ~empty & bus.out_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .push    (push[k]),
            .wr_data (bus.in_data),
            .pop     (pop[k]),
            .rd_data (rd_data[k]),
            .empty   (empty[k]),
            .full    (full[k])
        );
    end

    always_comb begin
        out_data_w = '0;
        for (int k = 0; k < LANES; k++) begin
            out_data_w[k*N +: N] = rd_data[k];
        end
    end

    assign bus.out_data  = out_data_w;
    assign bus.out_valid = ~empty;
    assign bus.lane_full = full;

endmodule

// File: tb/tb_demux_1to4_fifo.sv
// Directed and random bench for demux_1to4_fifo with a per-lane expected-word scoreboard.
module tb_demux_1to4_fifo;
    import demux_1to4_fifo_pkg::*;

    localparam int N     = 16;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_1to4_fifo_if #(.N(N)) bus ();

    demux_1to4_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]     exp_q [LANES][$];
    logic             stall_prev = 1'b0;
    logic [N-1:0]     prev_data;
    logic [SEL_W-1:0] prev_sel;
    logic             exp_ready;
    logic [N-1:0]     exp_word;
    logic [N-1:0]     words [LANES];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [SEL_W-1:0] sel, input logic [N-1:0] data);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
    endtask

    function automatic logic [N-1:0] head(input int k);
        return bus.out_data[k*N +: N];
    endfunction

    // Scoreboard: handshakes are resolved at the falling edge, where inputs and outputs are
    // settled and both reflect what the next rising edge will do.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) exp_q[k].delete();
            stall_prev = 1'b0;
        end else begin
            exp_ready = (exp_q[bus.in_sel].size() != DEPTH) || bus.out_ready[bus.in_sel];
            if (bus.in_valid) check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
            if (stall_prev) begin
                check("hold_valid", 64'(bus.in_valid), 64'(1'b1));
                check("hold_sel", 64'(bus.in_sel), 64'(prev_sel));
                check("hold_data", 64'(bus.in_data), 64'(prev_data));
            end
            for (int k = 0; k < LANES; k++) begin
                check("out_valid", 64'(bus.out_valid[k]), 64'(exp_q[k].size() != 0));
                check("lane_full", 64'(bus.lane_full[k]), 64'(exp_q[k].size() == DEPTH));
                if (bus.out_valid[k] && bus.out_ready[k] && exp_q[k].size() != 0) begin
                    exp_word = exp_q[k].pop_front();
                    check("pop_data", 64'(head(k)), 64'(exp_word));
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q[bus.in_sel].push_back(bus.in_data);
            stall_prev = bus.in_valid && !bus.in_ready;
            prev_data  = bus.in_data;
            prev_sel   = bus.in_sel;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", 64'(bus.out_valid), 64'(4'b0000));
        check("rst_lane_full", 64'(bus.lane_full), 64'(4'b0000));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("rst_out_data", 64'(bus.out_data), 64'(0));

        // Reset mid-stream with lane2 holding two words.
        drive(2'(LANE2), 16'hC001);
        tick();
        drive(2'(LANE2), 16'hC002);
        tick();
        bus.in_valid = 1'b0;
        check("pre_rst_full", 64'(bus.lane_full), 64'(4'b0100));
        rst = 1'b1;
        #2;
        check("async_out_valid", 64'(bus.out_valid), 64'(4'b0000));
        check("async_in_ready", 64'(bus.in_ready), 64'(1'b1));
        check("async_out_data", 64'(bus.out_data), 64'(0));
        check("async_lane_full", 64'(bus.lane_full), 64'(4'b0000));
        tick();
        rst = 1'b0;

        // Routing to each lane, one cycle latency.
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        for (int i = 0; i < LANES; i++) begin
            drive(2'(i), words[i]);
            tick();
            check("route_valid", 64'(bus.out_valid[i]), 64'(1'b1));
            check("route_head", 64'(head(i)), 64'(words[i]));
        end
        bus.in_valid = 1'b0;
        check("route_all_valid", 64'(bus.out_valid), 64'(4'b1111));
        bus.out_ready = 4'b1111;
        tick();
        bus.out_ready = 4'b0000;
        check("route_drained", 64'(bus.out_valid), 64'(4'b0000));

        // Fill lane1; other lanes keep accepting; a third lane1 push stalls.
        drive(2'(LANE1), 16'hA001);
        tick();
        drive(2'(LANE1), 16'hA002);
        tick();
        check("full_lane1", 64'(bus.lane_full), 64'(4'b0010));
        drive(2'(LANE3), 16'hB003);
        #1 check("lane3_ready", 64'(bus.in_ready), 64'(1'b1));
        tick();
        check("lane3_head", 64'(head(LANE3)), 64'(16'hB003));
        drive(2'(LANE1), 16'hA003);
        #1 check("full_stall", 64'(bus.in_ready), 64'(1'b0));
        tick();
        check("stall_full", 64'(bus.lane_full), 64'(4'b0010));
        check("stall_head", 64'(head(LANE1)), 64'(16'hA001));

        // Full lane accepts while its head pops.
        bus.out_ready = 4'b0010;
        #1 check("full_pop_ready", 64'(bus.in_ready), 64'(1'b1));
        tick();
        bus.in_valid = 1'b0;
        check("full_pop_head", 64'(head(LANE1)), 64'(16'hA002));
        check("full_pop_full", 64'(bus.lane_full[LANE1]), 64'(1'b1));
        tick();
        check("order_head", 64'(head(LANE1)), 64'(16'hA003));
        tick();
        check("lane1_empty", 64'(bus.out_valid[LANE1]), 64'(1'b0));
        bus.out_ready = 4'b1000;
        tick();
        bus.out_ready = 4'b0000;
        check("lane3_empty", 64'(bus.out_valid), 64'(4'b0000));

        // Pointer wrap-around on lane0.
        for (int i = 0; i < 7; i++) begin
            drive(2'(LANE0), N'(i));
            tick();
            bus.in_valid = 1'b0;
            check("wrap_head", 64'(head(LANE0)), 64'(i));
            bus.out_ready = 4'b0001;
            tick();
            bus.out_ready = 4'b0000;
            check("wrap_empty", 64'(bus.out_valid[LANE0]), 64'(1'b0));
        end

        // Random traffic; a stalled word is held until accepted.
        repeat (10000) begin
            if (!stall_prev) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 2'($urandom_range(0, 3));
                bus.in_data  = N'($urandom_range(0, 65535));
            end
            for (int k = 0; k < LANES; k++) bus.out_ready[k] = ($urandom_range(0, 2) == 0);
            tick();
        end
        if (stall_prev) begin
            bus.out_ready = 4'b1111;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        repeat (DEPTH + 1) tick();
        check("final_out_valid", 64'(bus.out_valid), 64'(4'b0000));
        for (int k = 0; k < LANES; k++) check("final_queue", 64'(exp_q[k].size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
